ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_host_tx_if.sv | 31 +++
 rtl/ps2_line_sync.sv | 39 +++
 rtl/ps2_host_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and its line synchronizer:
// the transmitter state encoding, default cycle constants for a 27 MHz clock,
// the common command codes, and the odd-parity helper used to build a frame.
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Default cycle counts at 27 MHz
  localparam int PS2_INHIBIT_CYCLES = 3240;    // 120 us clock-low inhibit
  localparam int PS2_START_HOLD     = 32;      // data low before clock release
  localparam int PS2_FIRST_TIMEOUT  = 405000;  // 15 ms until first device edge
  localparam int PS2_BIT_TIMEOUT    = 54000;   // 2 ms between device edges

  // Common host commands and the device acknowledge code
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
// Command handshake between a client and the PS/2 host transmitter.
//   tx_data  : command byte, sampled when tx_valid & tx_ready
//   tx_valid : client requests a send
//   tx_ready : transmitter can accept a byte
//   busy     : a frame is in progress (receiver should ignore the lines)
//   done     : one-cycle pulse, frame sent and acknowledged
//   error    : one-cycle pulse, timeout or missing acknowledge
// master = client side, slave = transmitter side.
// ----------------------------------------------------------------------------
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error
  );

endinterface

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Brings one asynchronous PS/2 pin into the clock domain and flags its
// falling edges.
//   clk, rst_n : clock, asynchronous active-low reset
//   line_in    : raw pin level
//   level      : synchronized level (two flops)
//   fall       : one-cycle pulse when the synchronized level goes 1 -> 0
// ----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Flops reset high: an idle PS/2 line is pulled up, so coming out of reset
  // must not look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts out one byte + odd parity + stop on device clock falls, then checks
// the device acknowledge.
//   CLOCK_27, RESET_N        : clock, asynchronous active-low reset
//   tx                       : command handshake (slave side)
//   ps2_clk_in, ps2_dat_in   : raw pin levels
//   ps2_clk_oe, ps2_dat_oe   : open-drain enables, 1 pulls the line low
// ----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_HOLD     = PS2_START_HOLD,
  parameter int FIRST_TIMEOUT  = PS2_FIRST_TIMEOUT,
  parameter int BIT_TIMEOUT    = PS2_BIT_TIMEOUT
) (
  input  logic          CLOCK_27,
  input  logic          RESET_N,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam logic [11:0] INH_LAST   = 12'(INHIBIT_CYCLES - 1);
  localparam logic [11:0] HOLD_LAST  = 12'(START_HOLD - 1);
  localparam logic [18:0] FIRST_LAST = 19'(FIRST_TIMEOUT - 1);
  localparam logic [18:0] BIT_LAST   = 19'(BIT_TIMEOUT - 1);
  localparam logic [3:0]  EDGE_ACK   = 4'd11;

  ps2_tx_state_t state, state_next;
  logic [11:0]   hold_cnt, hold_next;
  logic [18:0]   tmo_cnt, tmo_next;
  logic [3:0]    edge_cnt, edge_next;
  logic [7:0]    data_q, data_next;
  logic          par_q, par_next;
  logic          dat_oe_q, dat_oe_next;
  logic          done_q, done_next;
  logic          error_q, error_next;

  logic          clk_level, clk_fall;
  logic          dat_level, dat_fall_unused;
  logic          accept;
  logic [3:0]    edge_inc;
  logic [18:0]   tmo_limit;
  logic          tmo_expired;

  ps2_line_sync u_clk_sync (
    .clk     (CLOCK_27),
    .rst_n   (RESET_N),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  // Only the clock line's edges drive the frame; the data edge output is
  // not needed by the transmitter.
  ps2_line_sync u_dat_sync (
    .clk     (CLOCK_27),
    .rst_n   (RESET_N),
    .line_in (ps2_dat_in),
    .level   (dat_level),
    .fall    (dat_fall_unused)
  );

  // done/error are held off tx_ready so a waiting client is accepted only
  // in the cycle after the completion pulse.
  assign tx.tx_ready = (state == IDLE) & ~done_q & ~error_q;
  assign tx.busy     = (state != IDLE);
  assign tx.done     = done_q;
  assign tx.error    = error_q;
  assign accept      = tx.tx_valid & tx.tx_ready;

  // Clock enable decodes straight from state so reset releases it at once.
  assign ps2_clk_oe  = (state == INHIBIT) | (state == START);
  assign ps2_dat_oe  = dat_oe_q;

  always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      hold_cnt <= '0;
      tmo_cnt  <= '0;
      edge_cnt <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      tmo_cnt  <= tmo_next;
      edge_cnt <= edge_next;
      data_q   <= data_next;
      par_q    <= par_next;
      dat_oe_q <= dat_oe_next;
      done_q   <= done_next;
      error_q  <= error_next;
    end
  end

  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    tmo_next    = tmo_cnt;
    edge_next   = edge_cnt;
    data_next   = data_q;
    par_next    = par_q;
    dat_oe_next = dat_oe_q;
    done_next   = 1'b0;
    error_next  = 1'b0;

    edge_inc    = (edge_cnt == EDGE_ACK) ? EDGE_ACK : edge_cnt + 4'd1;
    // The device gets a long grace period to start clocking, then a
    // tighter limit between edges (also bounds the wait for bus idle).
    tmo_limit   = (edge_cnt == 4'd0) ? FIRST_LAST : BIT_LAST;
    tmo_expired = (tmo_cnt == tmo_limit);

    case (state)
      IDLE: begin
        dat_oe_next = 1'b0;
        if (accept) begin
          data_next  = tx.tx_data;
          par_next   = odd_parity(tx.tx_data);
          hold_next  = '0;
          state_next = INHIBIT;
        end
      end

      INHIBIT: begin
        if (hold_cnt == INH_LAST) begin
          hold_next   = '0;
          dat_oe_next = 1'b1;
          state_next  = START;
        end else begin
          hold_next = hold_cnt + 12'd1;
        end
      end

      START: begin
        if (hold_cnt == HOLD_LAST) begin
          edge_next  = '0;
          tmo_next   = '0;
          state_next = XFER;
        end else begin
          hold_next = hold_cnt + 12'd1;
        end
      end

      XFER: begin
        if (clk_fall) begin
          tmo_next  = '0;
          edge_next = edge_inc;
          if (edge_inc <= 4'd8) begin
            dat_oe_next = ~data_q[3'(edge_inc - 4'd1)];
          end else if (edge_inc == 4'd9) begin
            dat_oe_next = ~par_q;
          end else if (edge_inc == 4'd10) begin
            dat_oe_next = 1'b0;
          end else begin
            // Edge 11: the device pulls data low to acknowledge
            dat_oe_next = 1'b0;
            if (dat_level) begin
              error_next = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = WAIT_IDLE;
            end
          end
        end else if (tmo_expired) begin
          dat_oe_next = 1'b0;
          error_next  = 1'b1;
          state_next  = IDLE;
        end else begin
          tmo_next = tmo_cnt + 19'd1;
        end
      end

      WAIT_IDLE: begin
        if (clk_level & dat_level) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (tmo_expired) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_cnt + 19'd1;
        end
      end

      default: begin
        dat_oe_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

endmodule
